// File: rtl/nios_system_char_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nios_system_char_rx_ctrl
// Purpose  : 8N1 serial character receiver with a small byte FIFO behind an
//            Avalon-MM PIO-style slave. Bytes are received LSB first and pushed
//            into the FIFO when the stop bit is high.
// Revision : 1.0  initial release
//
// Ports
//   clk         system clock, all logic on the rising edge
//   reset_n     asynchronous active-low reset
//   address     slave word address (0 DATA, 1 STATUS, 2 CONTROL, 3 IRQ_MASK)
//   chipselect  slave select
//   read        read strobe (qualified by chipselect)
//   write_n     active-low write strobe (qualified by chipselect)
//   writedata   write data
//   in_port     asynchronous serial line, idle high
//   readdata    registered read data, valid the cycle after the access
//   irq         registered interrupt (only when CHAR_RX_IRQ_EN is defined)
//
// Register map
//   0 DATA     {24'b0, head byte}; a read pops one entry
//   1 STATUS   {count[3:0] @ [6:3], FERR @ [2], OVR @ [1], AVAIL @ [0]}
//   2 CONTROL  write: bit0 clears FERR/OVR, bit1 flushes the FIFO; reads 0
//   3 IRQ_MASK bits[1:0], present only with CHAR_RX_IRQ_EN (otherwise reads 0)
//
// Build option
//   CHAR_RX_IRQ_EN  adds the irq output and the IRQ_MASK register
// ============================================================================
module nios_system_char_rx_ctrl #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write_n,
  input  logic [31:0] writedata,
  input  logic        in_port,
  output logic [31:0] readdata
`ifdef CHAR_RX_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int            TW        = $clog2(CLKS_PER_BIT);
  localparam int            PW        = $clog2(FIFO_DEPTH);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]    DEPTH     = 4'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // --------------------------------------------------------------------------
  // Line synchronizer (resets to the idle level so reset never looks like a
  // start bit)
  // --------------------------------------------------------------------------
  logic [1:0] sync_q;
  logic       rx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], in_port};
  end

  assign rx = sync_q[1];

  // --------------------------------------------------------------------------
  // Receiver FSM
  // --------------------------------------------------------------------------
  logic [1:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          half_end, bit_end;
  logic          timer_clr, bit_smp, rx_push, rx_ferr;

  assign half_end = (timer_q == HALF_LAST);
  assign bit_end  = (timer_q == BIT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!rx) state_d = S_START;
      S_START: if (half_end) state_d = rx ? S_IDLE : S_DATA;
      S_DATA:  if (bit_end && (idx_q == 3'd7)) state_d = S_STOP;
      S_STOP:  if (bit_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    timer_clr = 1'b0;
    bit_smp   = 1'b0;
    rx_push   = 1'b0;
    rx_ferr   = 1'b0;
    case (state_q)
      S_IDLE:  timer_clr = 1'b1;
      S_START: timer_clr = half_end;
      S_DATA: begin
        timer_clr = bit_end;
        bit_smp   = bit_end;
      end
      S_STOP: begin
        timer_clr = bit_end;
        rx_push   = bit_end & rx;
        rx_ferr   = bit_end & ~rx;
      end
      default: timer_clr = 1'b1;
    endcase
  end

  // Bit timer, bit index and shift register
  always_comb begin
    timer_d = timer_clr ? '0 : timer_q + TW'(1);
    idx_d   = (state_q == S_IDLE) ? 3'd0 : (bit_smp ? idx_q + 3'd1 : idx_q);
    shift_d = bit_smp ? {rx, shift_q[7:1]} : shift_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_q <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'd0;
    end else begin
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // --------------------------------------------------------------------------
  // Bus decode
  // --------------------------------------------------------------------------
  logic rd_acc, wr_acc, ctrl_wr, flush, err_clr;
  logic unused_wdata;

  // A cycle with write_n low is a write, even if read is also high
  assign rd_acc  = chipselect & read & write_n;
  assign wr_acc  = chipselect & ~write_n;
  assign ctrl_wr = wr_acc & (address == 2'd2);
  assign flush   = ctrl_wr & writedata[1];
  assign err_clr = ctrl_wr & writedata[0];

  assign unused_wdata = ^writedata[31:2];

  // --------------------------------------------------------------------------
  // Byte FIFO
  // --------------------------------------------------------------------------
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [3:0]    count_q, count_d;
  logic          fifo_empty, fifo_full, pop, do_write, ovr_set;
  logic          ferr_q, ferr_d, ovr_q, ovr_d;

  assign fifo_empty = (count_q == 4'd0);
  assign fifo_full  = (count_q == DEPTH);
  assign pop        = rd_acc & (address == 2'd0) & ~fifo_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_write = 1'b0;
    ovr_set  = 1'b0;
    if (flush) begin
      // Flush wins over a same-cycle push; that byte is discarded silently
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = 4'd0;
    end else begin
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      if (rx_push) begin
        // A pop in the same cycle frees the slot the push lands in
        if (!fifo_full || pop) begin
          do_write = 1'b1;
          wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
          ovr_set = 1'b1;
        end
      end
      case ({do_write, pop})
        2'b10:   count_d = count_q + 4'd1;
        2'b01:   count_d = count_q - 4'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Error flags: a set in the same cycle as a clear takes priority
  always_comb begin
    ferr_d = err_clr ? 1'b0 : ferr_q;
    ovr_d  = err_clr ? 1'b0 : ovr_q;
    if (rx_ferr) ferr_d = 1'b1;
    if (ovr_set) ovr_d  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_write) mem_q[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 4'd0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  end

  // --------------------------------------------------------------------------
  // Optional interrupt
  // --------------------------------------------------------------------------
`ifdef CHAR_RX_IRQ_EN
  logic [1:0] irq_mask_q, irq_mask_d;
  logic       irq_q, irq_d;

  assign irq_mask_d = (wr_acc && (address == 2'd3)) ? writedata[1:0] : irq_mask_q;
  assign irq_d      = (~fifo_empty & irq_mask_q[0]) | ((ferr_q | ovr_q) & irq_mask_q[1]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask_q <= 2'b00;
      irq_q      <= 1'b0;
    end else begin
      irq_mask_q <= irq_mask_d;
      irq_q      <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

  // --------------------------------------------------------------------------
  // Read data register
  // --------------------------------------------------------------------------
  logic [31:0] readdata_q, readdata_d;

  always_comb begin
    readdata_d = 32'd0;
    if (rd_acc) begin
      case (address)
        2'd0:    if (!fifo_empty) readdata_d = {24'd0, mem_q[rd_ptr_q]};
        2'd1:    readdata_d = {25'd0, count_q, ferr_q, ovr_q, ~fifo_empty};
`ifdef CHAR_RX_IRQ_EN
        2'd3:    readdata_d = {30'd0, irq_mask_q};
`endif
        default: readdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata_q <= 32'd0;
    else          readdata_q <= readdata_d;
  end

  assign readdata = readdata_q;

endmodule
`default_nettype wire
